// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry, reset PC and the fetch buffer entry layout.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {instr, pc}; flush empties it and dominates push/pop.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output fetch_entry_t head_o
);

  fetch_entry_t entry_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = entry_q[rd_ptr_q];

  // Push into a full buffer is only safe when the head leaves in the same cycle,
  // because the freed slot is the one the write pointer already points at.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        entry_q[gi] <= '0;
      end else if (!flush_i && do_push && (wr_ptr_q == 1'(gi))) begin
        entry_q[gi] <= push_entry_i;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single outstanding read tracking, memory pin mux and decode handshake.
// Optional store port through the memory pins is enabled with FETCH_STORE_PORT_EN.
module fetch_unit #(
  parameter int                ADDR_W    = cpu_pkg::ADDR_W,
  parameter int                DATA_W    = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
`ifdef FETCH_STORE_PORT_EN
  ,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready
`endif
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic              pop, push, issue, store_cycle;
  logic              buf_full, buf_empty;
  logic [1:0]        occupancy;
  logic [2:0]        demand;
  fetch_entry_t      head, push_entry;

  assign instr_valid = !buf_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign pop         = instr_valid && instr_ready;

  // The outstanding read counts as an occupied slot so a full buffer can never receive a push.
  assign occupancy = buf_full ? 2'd2 : (buf_empty ? 2'd0 : 2'd1);
  assign demand    = {1'b0, occupancy} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = !reset && !halt && !redirect_valid && !store_cycle
                     && (demand < 3'(BUF_DEPTH));

  assign push       = inflight_q && !kill_q && !redirect_valid;
  assign push_entry = '{instr: mem_data_out, pc: inflight_pc_q};

`ifdef FETCH_STORE_PORT_EN
  assign store_cycle = st_valid && !redirect_valid && !reset;
  assign st_ready    = store_cycle;
  assign mem_enable  = store_cycle;
  assign mem_address = store_cycle ? st_addr : pc_q;
  assign mem_data_in = store_cycle ? st_data : '0;
`else
  assign store_cycle = 1'b0;
  assign mem_enable  = 1'b0;
  assign mem_address = pc_q;
  assign mem_data_in = '0;
`endif

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    kill_d        = kill_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      kill_d = inflight_q;
    end else if (issue) begin
      pc_d          = pc_q + ADDR_W'(1);
      inflight_pc_d = pc_q;
      inflight_d    = 1'b1;
      kill_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
    end
  end

  // A pop coinciding with a redirect is dropped; the flush discards the head anyway.
  fetch_buffer u_buf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop && !redirect_valid),
    .flush_i      (redirect_valid),
    .full_o       (buf_full),
    .empty_o      (buf_empty),
    .head_o       (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a 256x16 registered-read memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_enable;
  logic [7:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halt = 1'b0;
`ifdef FETCH_STORE_PORT_EN
  logic        st_valid = 1'b0;
  logic [7:0]  st_addr = '0;
  logic [15:0] st_data = '0;
  logic        st_ready;
`endif

  logic [15:0] mem [256];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .mem_enable     (mem_enable),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef FETCH_STORE_PORT_EN
    ,
    .st_valid       (st_valid),
    .st_addr        (st_addr),
    .st_data        (st_data),
    .st_ready       (st_ready)
`endif
  );

  always @(posedge clk) begin
    if (mem_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  always @(negedge clk) begin
    if (!reset && dut.u_buf.push_i && dut.u_buf.full_o && !dut.u_buf.pop_i) begin
      n_fail++;
      $display("FAIL push_when_full: push=%b full=%b, required no push into full buffer",
               dut.u_buf.push_i, dut.u_buf.full_o);
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input logic rdy);
    reset = 1'b1;
    instr_ready = rdy;
    halt = 1'b0;
    redirect_valid = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    instr_ready = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    n_tests++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got %h, required 0000", instr); end
    n_tests++; if (instr_pc !== 8'h00) begin n_fail++; $display("FAIL rst_instr_pc: got %h, required 00", instr_pc); end
    n_tests++; if (mem_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mem_enable: got %b, required 0", mem_enable); end
    n_tests++; if (mem_address !== 8'h00) begin n_fail++; $display("FAIL rst_mem_address: got %h, required 00", mem_address); end
    n_tests++; if (mem_data_in !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_data_in: got %h, required 0000", mem_data_in); end
`ifdef FETCH_STORE_PORT_EN
    n_tests++; if (st_ready !== 1'b0) begin n_fail++; $display("FAIL rst_st_ready: got %b, required 0", st_ready); end
`endif
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (instr_valid !== (c >= 2)) begin
        n_fail++; $display("FAIL first_fetch_valid c%0d: got %b, required %b", c, instr_valid, c >= 2);
      end
      if (c == 2) begin
        n_tests++; if (instr !== 16'h0001 || instr_pc !== 8'h00) begin
          n_fail++; $display("FAIL first_fetch_0: got %h@%h, required 0001@00", instr, instr_pc);
        end
      end
      if (c == 3) begin
        n_tests++; if (instr !== 16'h0002 || instr_pc !== 8'h01) begin
          n_fail++; $display("FAIL first_fetch_1: got %h@%h, required 0002@01", instr, instr_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure;
    reset_dut(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_tests++; if (mem_address !== 8'h02) begin
          n_fail++; $display("FAIL bp_pc_held c%0d: got %h, required 02", c, mem_address);
        end
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
          n_fail++; $display("FAIL bp_head c%0d: got valid=%b pc=%h, required valid=1 pc=00", c, instr_valid, instr_pc);
        end
      end
      next_cycle();
    end
    instr_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      logic [7:0] want_pc;
      want_pc = 8'(c);
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== want_pc || instr !== mem[want_pc]) begin
        n_fail++; $display("FAIL bp_release %0d: got valid=%b %h@%h, required %h@%h",
                           c, instr_valid, instr, instr_pc, mem[want_pc], want_pc);
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect;
    reset_dut(1'b1);
    next_cycle(); next_cycle(); next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 8'hAA;
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        n_tests++; if (instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL redir_gap R+%0d: got valid=%b, required 0", k, instr_valid);
        end
      end else begin
        logic [7:0] want_pc;
        want_pc = (k == 3) ? 8'hAA : 8'hAB;
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== want_pc || instr !== mem[want_pc]) begin
          n_fail++; $display("FAIL redir_target R+%0d: got valid=%b %h@%h, required %h@%h",
                             k, instr_valid, instr, instr_pc, mem[want_pc], want_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_wrap;
    reset_dut(1'b1);
    next_cycle(); next_cycle(); next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        logic [7:0] want_pc;
        want_pc = 8'hFF + 8'(k - 3);
        n_tests++; if (instr_valid !== 1'b1 || instr_pc !== want_pc || instr !== mem[want_pc]) begin
          n_fail++; $display("FAIL wrap R+%0d: got valid=%b %h@%h, required %h@%h",
                             k, instr_valid, instr, instr_pc, mem[want_pc], want_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_halt;
    logic [7:0] exp_pc;
    logic [7:0] held;
    int         xfers;
    reset_dut(1'b1);
    exp_pc = 8'h00;
    held = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        n_tests++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
          n_fail++; $display("FAIL halt_pre: got %h@%h, required %h@%h", instr, instr_pc, mem[exp_pc], exp_pc);
        end
        exp_pc++;
      end
      next_cycle();
    end
    halt = 1'b1;
    xfers = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) held = mem_address;
      else begin
        n_tests++; if (mem_address !== held) begin
          n_fail++; $display("FAIL halt_no_issue c%0d: got addr %h, required %h", c, mem_address, held);
        end
      end
      if (instr_valid && instr_ready) begin
        n_tests++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
          n_fail++; $display("FAIL halt_drain: got %h@%h, required %h@%h", instr, instr_pc, mem[exp_pc], exp_pc);
        end
        exp_pc++;
        xfers++;
      end
      next_cycle();
    end
    halt = 1'b0;
    n_tests++; if (xfers != 2) begin
      n_fail++; $display("FAIL halt_drain_count: got %0d, required 2", xfers);
    end
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        n_tests++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
          n_fail++; $display("FAIL halt_resume: got %h@%h, required %h@%h", instr, instr_pc, mem[exp_pc], exp_pc);
        end
        exp_pc++;
        xfers++;
      end
      next_cycle();
    end
    n_tests++; if (xfers != 6) begin
      n_fail++; $display("FAIL halt_resume_count: got %0d, required 6", xfers);
    end
  endtask

`ifdef FETCH_STORE_PORT_EN
  task automatic test_store;
    logic [7:0] pc_before;
    reset_dut(1'b1);
    next_cycle(); next_cycle(); next_cycle();
    @(negedge clk);
    pc_before = mem_address;
    next_cycle();
    st_valid = 1'b1;
    st_addr = 8'hBB;
    st_data = 16'hBBBB;
    @(negedge clk);
    n_tests++; if (mem_enable !== 1'b1 || mem_address !== 8'hBB || mem_data_in !== 16'hBBBB || st_ready !== 1'b1) begin
      n_fail++; $display("FAIL store_cycle: got en=%b addr=%h data=%h rdy=%b, required 1 BB BBBB 1",
                         mem_enable, mem_address, mem_data_in, st_ready);
    end
    next_cycle();
    st_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (mem_enable !== 1'b0 || mem_address !== pc_before + 8'd1) begin
      n_fail++; $display("FAIL store_pc_held: got en=%b addr=%h, required 0 %h", mem_enable, mem_address, pc_before + 8'd1);
    end
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 8'hBB;
    next_cycle();
    redirect_valid = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++; if (instr_valid !== 1'b1 || instr !== 16'hBBBB || instr_pc !== 8'hBB) begin
      n_fail++; $display("FAIL store_readback: got valid=%b %h@%h, required BBBB@BB", instr_valid, instr, instr_pc);
    end
    next_cycle();
  endtask
`endif

  task automatic test_random;
    logic [7:0] exp_pc;
    logic       prev_redir;
    reset_dut(1'b1);
    exp_pc = 8'h00;
    prev_redir = 1'b0;
    for (int c = 0; c < 400; c++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (prev_redir) begin
        n_tests++; if (instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_redir_gap c%0d: got valid=%b, required 0", c, instr_valid);
        end
      end
      n_tests++; if (mem_enable !== 1'b0) begin
        n_fail++; $display("FAIL rand_mem_enable c%0d: got %b, required 0", c, mem_enable);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        n_tests++; if (instr_pc !== exp_pc || instr !== mem[exp_pc]) begin
          n_fail++; $display("FAIL rand_xfer c%0d: got %h@%h, required %h@%h", c, instr, instr_pc, mem[exp_pc], exp_pc);
        end else begin
          $display("[TB] xfer c%0d pc=%h instr=%h", c, instr_pc, instr);
        end
        exp_pc++;
      end
      prev_redir = redirect_valid;
      next_cycle();
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= {i[7:0], i[7:0]};
    mem[0] <= 16'h0001;
    mem[1] <= 16'h0002;
    #1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
`ifdef FETCH_STORE_PORT_EN
    test_store();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
